// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with branch/jump target selection,
// misaligned-target fault capture, trap redirect and a retired-instruction count.
//
// Ports:
//   clk        : clock; all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   en         : advance enable (0 = stall)
//   inst_type  : 0 load, 1 imm, 2 store, 3 reg, 4 lui, 5 auipc, 6 branch, 7 jalr, 8 jal
//   fun3       : branch condition select
//   imm        : sign-extended immediate
//   rs1        : jalr base register value
//   zcnv       : {Z,C,N,V} flags of rs1-rs2 (C = 1 means no borrow)
//   trap_req   : redirect request, highest priority
//   trap_vec   : redirect target (low alignment bits are dropped)
//   pc         : current PC (registered)
//   pc_plus4   : pc + 4, the link value
//   fault      : a misaligned-target fault is pending
//   fault_addr : the offending target (registered)
//   instret    : retired-instruction count
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
  parameter int              IALIGN       = 4,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       inst_type,
  input  logic [2:0]       fun3,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1,
  input  logic [3:0]       zcnv,
  input  logic             trap_req,
  input  logic [XLEN-1:0]  trap_vec,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             fault,
  output logic [XLEN-1:0]  fault_addr,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic {S_RUN = 1'b0, S_FAULT = 1'b1} state_t;

  localparam logic [XLEN-1:0]  PC_FOUR   = XLEN'(3'd4);
  localparam logic [XLEN-1:0]  BIT0_MASK = ~XLEN'(2'b01);
  // Trap targets are forced onto an instruction boundary.
  localparam logic [XLEN-1:0]  TRAP_MASK = (IALIGN == 2) ? ~XLEN'(2'b01) : ~XLEN'(2'b11);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   fault_addr_q, fault_addr_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic              taken_s;
  logic              misalign_s;
  logic [XLEN-1:0]   pc_plus4_s;
  logic [XLEN-1:0]   target_s;
  logic [XLEN-1:0]   trap_tgt_s;

  assign pc_plus4_s = pc_q + PC_FOUR;
  assign trap_tgt_s = trap_vec & TRAP_MASK;

  // Branch condition from the {Z,C,N,V} flags.
  always_comb begin
    taken_s = 1'b0;
    case (fun3)
      3'b000:  taken_s = zcnv[3];
      3'b001:  taken_s = ~zcnv[3];
      3'b100:  taken_s = zcnv[1] ^ zcnv[0];
      3'b101:  taken_s = ~(zcnv[1] ^ zcnv[0]);
      3'b110:  taken_s = ~zcnv[2];
      3'b111:  taken_s = zcnv[2];
      default: taken_s = 1'b0;
    endcase
  end

  // Next-PC target selection and alignment check.
  always_comb begin
    target_s = pc_plus4_s;
    case (inst_type)
      4'd6: begin
        if (taken_s) begin
          target_s = pc_q + imm;
        end else begin
          target_s = pc_plus4_s;
        end
      end
      4'd7:    target_s = (rs1 + imm) & BIT0_MASK;
      4'd8:    target_s = pc_q + imm;
      default: target_s = pc_plus4_s;
    endcase
    // With 2-byte alignment every target is already legal.
    if (IALIGN == 4) begin
      misalign_s = target_s[1];
    end else begin
      misalign_s = 1'b0;
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_VECTOR;
      fault_addr_q <= {XLEN{1'b0}};
      instret_q    <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_addr_q <= fault_addr_d;
      instret_q    <= instret_d;
    end
  end

  // Next-state logic; a trap overrides stall and the fault check.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    instret_d    = instret_q;
    if (trap_req) begin
      state_d = S_RUN;
      pc_d    = trap_tgt_s;
    end else begin
      case (state_q)
        S_RUN: begin
          if (!en) begin
            state_d = S_RUN;
          end else if (misalign_s) begin
            state_d      = S_FAULT;
            fault_addr_d = target_s;
          end else begin
            pc_d      = target_s;
            instret_d = instret_q + CNT_ONE;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_RUN;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    fault      = (state_q == S_FAULT);
    pc         = pc_q;
    pc_plus4   = pc_plus4_s;
    fault_addr = fault_addr_q;
    instret    = instret_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst2_n = 1'b0;
  logic        en = 1'b0;
  logic        en2 = 1'b0;
  logic [3:0]  inst_type = 4'd0;
  logic [2:0]  fun3 = 3'd0;
  logic [31:0] imm = 32'd0;
  logic [31:0] rs1 = 32'd0;
  logic [3:0]  zcnv = 4'd0;
  logic        trap_req = 1'b0;
  logic [31:0] trap_vec = 32'd0;

  logic [31:0] pc, pc_plus4, fault_addr, instret;
  logic        fault;
  logic [31:0] pc2, pc_plus4_2, fault_addr2;
  logic [1:0]  instret2;
  logic        fault2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          idx;
    logic        which;
    logic [31:0] pc;
    logic        fault;
    logic [31:0] fa;
    logic [31:0] ir;
  } exp_t;

  exp_t exp_q[$];
  int   step_idx = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'd0), .IALIGN(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .inst_type(inst_type), .fun3(fun3),
    .imm(imm), .rs1(rs1), .zcnv(zcnv), .trap_req(trap_req), .trap_vec(trap_vec),
    .pc(pc), .pc_plus4(pc_plus4), .fault(fault), .fault_addr(fault_addr),
    .instret(instret)
  );

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'd0), .IALIGN(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .en(en2), .inst_type(inst_type), .fun3(fun3),
    .imm(imm), .rs1(rs1), .zcnv(zcnv), .trap_req(trap_req), .trap_vec(trap_vec),
    .pc(pc2), .pc_plus4(pc_plus4_2), .fault(fault2), .fault_addr(fault_addr2),
    .instret(instret2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
  task automatic step(input logic [3:0] t, input logic [2:0] f3, input logic [31:0] im,
                      input logic [31:0] r1, input logic [3:0] z, input logic e,
                      input logic tr, input logic [31:0] tv, input logic w,
                      input logic [31:0] e_pc, input logic e_f, input logic [31:0] e_fa,
                      input logic [31:0] e_ir);
    exp_t x;
    @(negedge clk);
    inst_type = t; fun3 = f3; imm = im; rs1 = r1; zcnv = z;
    trap_req = tr; trap_vec = tv;
    if (w) begin en2 = e; en = 1'b0; end
    else   begin en = e;  en2 = 1'b0; end
    x.idx = step_idx; x.which = w; x.pc = e_pc; x.fault = e_f; x.fa = e_fa; x.ir = e_ir;
    exp_q.push_back(x);
    step_idx++;
  endtask

  // Monitor: after each rising edge, compare the DUT state with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!e.which) begin
          chk($sformatf("s%0d pc", e.idx), pc, e.pc);
          chk($sformatf("s%0d pc_plus4", e.idx), pc_plus4, e.pc + 32'd4);
          chk($sformatf("s%0d fault", e.idx), {31'd0, fault}, {31'd0, e.fault});
          chk($sformatf("s%0d fault_addr", e.idx), fault_addr, e.fa);
          chk($sformatf("s%0d instret", e.idx), instret, e.ir);
        end else begin
          chk($sformatf("s%0d ia2 pc", e.idx), pc2, e.pc);
          chk($sformatf("s%0d ia2 fault", e.idx), {31'd0, fault2}, {31'd0, e.fault});
          chk($sformatf("s%0d ia2 fault_addr", e.idx), fault_addr2, e.fa);
          chk($sformatf("s%0d ia2 instret", e.idx), {30'd0, instret2}, e.ir);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while rst_n is held low.
    step(4'd0, 3'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    rst_n = 1'b1;
    // Sequential flow.
    step(4'd1, 3'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd4,  1'b0, 32'd0, 32'd1);
    step(4'd1, 3'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd8,  1'b0, 32'd0, 32'd2);
    step(4'd1, 3'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd12, 1'b0, 32'd0, 32'd3);
    // Branch conditions.
    step(4'd6, 3'b000, 32'd16, 32'd0, 4'b0000, 1'b1, 1'b0, 32'd0, 1'b0, 32'd16,  1'b0, 32'd0, 32'd4);
    step(4'd6, 3'b000, 32'd16, 32'd0, 4'b1000, 1'b1, 1'b0, 32'd0, 1'b0, 32'd32,  1'b0, 32'd0, 32'd5);
    step(4'd6, 3'b110, 32'd16, 32'd0, 4'b0100, 1'b1, 1'b0, 32'd0, 1'b0, 32'd36,  1'b0, 32'd0, 32'd6);
    step(4'd6, 3'b101, 32'd16, 32'd0, 4'b0011, 1'b1, 1'b0, 32'd0, 1'b0, 32'd52,  1'b0, 32'd0, 32'd7);
    step(4'd6, 3'b001, 32'd16, 32'd0, 4'b0000, 1'b1, 1'b0, 32'd0, 1'b0, 32'd68,  1'b0, 32'd0, 32'd8);
    step(4'd6, 3'b010, 32'd16, 32'd0, 4'b1000, 1'b1, 1'b0, 32'd0, 1'b0, 32'd72,  1'b0, 32'd0, 32'd9);
    step(4'd6, 3'b100, 32'd16, 32'd0, 4'b0010, 1'b1, 1'b0, 32'd0, 1'b0, 32'd88,  1'b0, 32'd0, 32'd10);
    step(4'd6, 3'b111, 32'd16, 32'd0, 4'b0100, 1'b1, 1'b0, 32'd0, 1'b0, 32'd104, 1'b0, 32'd0, 32'd11);
    // jal backwards, reserved type, aligned jalr.
    step(4'd8,  3'd0, 32'hFFFF_FFF8, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd96,  1'b0, 32'd0, 32'd12);
    step(4'd12, 3'd0, 32'd0,         32'd0, 4'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd100, 1'b0, 32'd0, 32'd13);
    step(4'd7,  3'd0, 32'd15,        32'd9, 4'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd24,  1'b0, 32'd0, 32'd14);
    // Misaligned jalr -> fault, then held for 3 cycles.
    step(4'd7, 3'd0, 32'd13, 32'd9, 4'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd24, 1'b1, 32'd22, 32'd14);
    step(4'd1, 3'd0, 32'd0,  32'd0, 4'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd24, 1'b1, 32'd22, 32'd14);
    step(4'd8, 3'd0, 32'd64, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd24, 1'b1, 32'd22, 32'd14);
    step(4'd7, 3'd0, 32'd0,  32'd0, 4'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd24, 1'b1, 32'd22, 32'd14);
    // Trap out of fault.
    step(4'd1, 3'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 32'h103, 1'b0, 32'h100, 1'b0, 32'd22, 32'd14);
    // Stall.
    for (int i = 0; i < 4; i++) begin
      step(4'd8, 3'd0, 32'd64, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'h100, 1'b0, 32'd22, 32'd14);
    end
    // Trap wins over a misaligned target with en=1.
    step(4'd7, 3'd0, 32'd13, 32'd9, 4'd0, 1'b1, 1'b1, 32'h206, 1'b0, 32'h204, 1'b0, 32'd22, 32'd14);
    step(4'd1, 3'd0, 32'd0,  32'd0, 4'd0, 1'b1, 1'b0, 32'd0,   1'b0, 32'h208, 1'b0, 32'd22, 32'd15);
    step(4'd7, 3'd0, 32'd13, 32'd9, 4'd0, 1'b1, 1'b0, 32'd0,   1'b0, 32'h208, 1'b1, 32'd22, 32'd15);
    step(4'd1, 3'd0, 32'd0,  32'd0, 4'd0, 1'b0, 1'b0, 32'd0,   1'b0, 32'h208, 1'b1, 32'd22, 32'd15);
    // Asynchronous reset mid-FAULT, away from any clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst pc", pc, 32'd0);
    chk("async rst fault", {31'd0, fault}, 32'd0);
    chk("async rst fault_addr", fault_addr, 32'd0);
    chk("async rst instret", instret, 32'd0);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    // PC wrap.
    step(4'd1, 3'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'd0, 32'd0);
    step(4'd1, 3'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0,         1'b0, 32'd0,         1'b0, 32'd0, 32'd1);
    rst2_n = 1'b1;
    // IALIGN=2 instance with a 2-bit counter.
    step(4'd7, 3'd0, 32'd13, 32'd9, 4'd0, 1'b1, 1'b0, 32'd0,   1'b1, 32'd22,  1'b0, 32'd0, 32'd1);
    step(4'd1, 3'd0, 32'd0,  32'd0, 4'd0, 1'b1, 1'b0, 32'd0,   1'b1, 32'd26,  1'b0, 32'd0, 32'd2);
    step(4'd1, 3'd0, 32'd0,  32'd0, 4'd0, 1'b1, 1'b0, 32'd0,   1'b1, 32'd30,  1'b0, 32'd0, 32'd3);
    step(4'd1, 3'd0, 32'd0,  32'd0, 4'd0, 1'b1, 1'b0, 32'd0,   1'b1, 32'd34,  1'b0, 32'd0, 32'd0);
    step(4'd1, 3'd0, 32'd0,  32'd0, 4'd0, 1'b1, 1'b1, 32'h103, 1'b1, 32'h102, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    trap_req = 1'b0; en = 1'b0; en2 = 1'b0;
    @(posedge clk);
    #5;
    chk("scoreboard drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and PC width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, meaning the PC value loaded on reset.
REQ-003 SHALL have parameter IALIGN, default 4, meaning the instruction alignment in bytes; legal values are 2 and 4.
REQ-004 SHALL have parameter CNT_W, default 32, meaning the width of the retired-instruction counter.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: advance enable; 0 means stall.
REQ-008 SHALL have port inst_type, input, 4 bits: 0 load, 1 imm, 2 store, 3 reg, 4 lui, 5 auipc, 6 branch, 7 jalr, 8 jal; 9-15 reserved.
REQ-009 SHALL have port fun3, input, 3 bits: branch condition select.
REQ-010 SHALL have port imm, input, XLEN bits: sign-extended immediate.
REQ-011 SHALL have port rs1, input, XLEN bits: jalr base register value.
REQ-012 SHALL have port zcnv, input, 4 bits: flags {Z,C,N,V} (bit 3 = Z) from rs1-rs2; C = carry-out (1 = no borrow).
REQ-013 SHALL have port trap_req, input, 1 bit: redirect request.
REQ-014 SHALL have port trap_vec, input, XLEN bits: redirect target.
REQ-015 SHALL have port pc, output, XLEN bits: current PC (registered).
REQ-016 SHALL have port pc_plus4, output, XLEN bits: pc+4 (link value, combinational from pc).
REQ-017 SHALL have port fault, output, 1 bit: misaligned-target fault is pending.
REQ-018 SHALL have port fault_addr, output, XLEN bits: the offending target (registered).
REQ-019 SHALL have port instret, output, CNT_W bits: count of retired (advanced) instructions.

Function
REQ-020 SHALL implement a two-state FSM, RUN and FAULT.
REQ-021 In RUN, with en=1 and trap_req=0, SHALL compute the target as follows: branch taken or jal -> pc+imm; jalr -> (rs1+imm) with bit 0 cleared; all other types, including reserved types and untaken branches -> pc+4.
REQ-022 Branch taken SHALL be decided by fun3 as follows: 000 Z=1; 001 Z=0; 100 N!=V; 101 N==V; 110 C=0; 111 C=1; 010/011 never taken.
REQ-023 All additions SHALL be modulo 2^XLEN, wrapping silently with no fault for wrap.
REQ-024 In RUN, if target[1]=1 and IALIGN=4, SHALL leave pc unchanged, register fault_addr=target, set fault=1, not increment instret, and enter FAULT the next cycle.
REQ-025 With IALIGN=2, SHALL never fault, because bit 0 is already clear for all targets.
REQ-026 In RUN, on an aligned target, SHALL set pc<=target and instret<=instret+1 on the next clock edge (1-cycle latency).
REQ-027 With en=0 and trap_req=0, SHALL hold pc, instret, state and fault unchanged.
REQ-028 In FAULT, SHALL hold pc and fault_addr and keep fault=1 regardless of en or inst_type.
REQ-029 In any state, trap_req=1 SHALL take priority over en and over the fault check: pc<=trap_vec with bits [log2(IALIGN)-1:0] cleared, fault<=0, state<=RUN, instret unchanged.
REQ-030 instret SHALL wrap from all-ones to 0.

Reset
REQ-031 rst_n=0 SHALL immediately (asynchronously) force pc=RESET_VECTOR, state=RUN, fault=0, fault_addr=0, instret=0, including mid-FAULT.
REQ-032 Release of rst_n SHALL be followed by normal operation from the first rising clk edge at which rst_n=1.

Verification
REQ-033 With XLEN=32, RESET_VECTOR=0, IALIGN=4: release reset, en=1, inst_type=1 for 3 cycles -> pc=4, 8, 12; instret=3.
REQ-034 At pc=12, inst_type=6, fun3=000, imm=16: Z=0 -> pc=16; then Z=1 -> pc=32. fun3=110 with C=1 -> pc+4; fun3=101 with N=1, V=1 -> pc+imm.
REQ-035 inst_type=7, rs1=9, imm=15 -> pc=24. rs1=9, imm=13 -> fault=1, fault_addr=22, pc holds for 3 cycles. Then trap_req=1, trap_vec=0x103 -> pc=0x100, fault=0.
REQ-036 en=0 for 4 cycles with inst_type=8, imm=64 -> pc and instret unchanged. Assert rst_n=0 mid-FAULT -> pc=0 and fault=0 without a clock edge.
REQ-037 Same misaligned jalr with IALIGN=2 -> pc=22, no fault. At pc=0xFFFFFFFC, inst_type=1 -> pc=0.
